dooz_matrix_display: RTL
========================

// Module: dooz_matrix_display
// PURPOSE
//  Downstream display stage for the Dooz (tic-tac-toe) game core. Consumes the
//  core's board/status outputs (selectA, selectB, turnA, turnB, winnerA, winnerB,
//  equal) and drives a row-scanned 3x3 bicolour LED matrix (A=red, B=green),
//  plus turn indicators. Winner cells blink on a win; the whole board blinks on a draw.
// PARAMETERS
//  SCAN_DIV      1000  clocks per row period (>= BLANK_CYC+2)
//  BLANK_CYC     2     clocks at start of each row period with all columns off (anti-ghost)
//  BLINK_FRAMES  64    complete 3-row frames per blink half-period
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  selectA    in   9  cells owned by A; bit i = cell i+1
//  selectB    in   9  cells owned by B; same mapping
//  turnA      in   1  A to move
//  turnB      in   1  B to move
//  winnerA    in   1  A has won
//  winnerB    in   1  B has won
//  equal      in   1  draw
//  row_n      out  3  active-low row enables, at most one low
//  col_red    out  3  red column drives for the active row, bit c = column c
//  col_green  out  3  green column drives for the active row
//  led_turnA  out  1  A turn lamp
//  led_turnB  out  1  B turn lamp
//  conflict   out  1  a cell is claimed by both A and B
// BEHAVIOUR
//  - Cell mapping: cell index k=0..8 -> row k/3, col k%3.
//  - Reset (async, reset=0): row_n=111, col_red=col_green=000, led_turnA/B=0,
//    conflict=0; counters, row index, blink phase, shadows and result state cleared.
//    Takes effect without a clock edge, including mid-row.
//  - Scan: div_cnt runs 0..SCAN_DIV-1. At terminal count the row advances 0->1->2->0.
//    After reset release, row 0 is active first.
//    row_n drives the active row low for the full period. Columns are 000 while
//    div_cnt<BLANK_CYC, then show the row data. All outputs are registered.
//  - Frame boundary: the terminal count of row 2. At that point all inputs are
//    copied into shadow registers, so the display never tears mid-frame.
//    Input-to-display latency is at most 1 frame + 1 clock.
//  - Blink: frame_cnt counts 0..BLINK_FRAMES-1 at each frame boundary.
//    At wrap it toggles blink (reset value 0 = off phase).
//  - Result FSM (evaluated on shadows at the frame boundary): states PLAY, WIN_A,
//    WIN_B, DRAW.
//    - Priority: winnerA > winnerB > equal. Any state -> PLAY when all three are 0.
//    - From a WIN state, only a change to the higher-priority flag or a return to
//      PLAY changes state.
//  - Cell colours: red=shA[k], green=shB[k], gated per state:
//    - PLAY: steady.
//    - WIN_A: red gated by blink; green steady.
//    - WIN_B: green gated by blink; red steady.
//    - DRAW: both gated by blink.
//    - A cell set in both shadows shows red and green together.
//  - led_turnA = shTurnA & (state==PLAY); led_turnB likewise.
//  - conflict = |(shA & shB), registered, updated at the frame boundary.
//  - Input changes between boundaries are ignored until the next boundary.
// STRUCTURE
//  - Package dooz_pkg:
//    - localparams CELLS=9, ROWS=3, COLS=3.
//    - Result-state encoding PLAY=2'd0, WIN_A=2'd1, WIN_B=2'd2, DRAW=2'd3.
//  - Sub-module dooz_scan_timer:
//    - Owns div_cnt, row index, frame_cnt and blink.
//    - Outputs row_idx[1:0], blank, frame_stb (1-clk pulse) and blink.
//  - The top module holds the shadows, result FSM, column mux and output registers.
// TESTING (bench params SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2)
//  1. reset=0 mid-row 1 -> row_n=111 and cols 000 immediately, no clock needed.
//     Release -> row_n=110 with cols 000 for 1 clk, then row data.
//  2. selectA=9'h001, selectB=9'h100 -> row0 col_red=001; row2 col_green=100.
//     An input change mid-frame is not visible until after the next frame boundary.
//  3. winnerA=1, selectA=9'b001010100, selectB=9'b000000011 -> red diagonal
//     (r0c2, r1c1, r2c0) alternates on/off every 2 frames; green r0c0/r0c1 steady;
//     led_turnA=led_turnB=0.
//  4. equal=1, selectA=9'b101011010, selectB=9'b010100101 -> all 9 cells blink
//     in phase. Dropping equal to 0 -> steady display from the next frame.
//  5. turnB=1, no winner -> led_turnB=1, led_turnA=0. Assert winnerB -> led_turnB=0
//     from the next frame.
//  6. selectA=selectB=9'h010 -> conflict=1; r1c1 col_red=col_green=010.
//     winnerA and winnerB both 1 -> WIN_A behaviour.

Source files
------------

// File: rtl/dooz_pkg.sv
// Shared constants, result-state encoding and small row helpers for the
// Dooz matrix display.
package dooz_pkg;

    localparam int CELLS = 9;
    localparam int ROWS  = 3;
    localparam int COLS  = 3;

    // Result-state encoding
    localparam logic [1:0] PLAY  = 2'd0;
    localparam logic [1:0] WIN_A = 2'd1;
    localparam logic [1:0] WIN_B = 2'd2;
    localparam logic [1:0] DRAW  = 2'd3;

    // Select the three cells of one row; bit c of the result is column c.
    function automatic logic [2:0] row_cells(input logic [8:0] cells, input logic [1:0] row);
        logic [2:0] r;
        case (row)
            2'd0:    r = cells[2:0];
            2'd1:    r = cells[5:3];
            2'd2:    r = cells[8:6];
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Active-low one-hot row enable; an out-of-range row leaves all rows off.
    function automatic logic [2:0] row_enable_n(input logic [1:0] row);
        logic [2:0] r;
        case (row)
            2'd0:    r = 3'b110;
            2'd1:    r = 3'b101;
            2'd2:    r = 3'b011;
            default: r = 3'b111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dooz_scan_timer.sv
// Row scan timebase: row period divider, row index, frame counter and
// blink phase for the Dooz matrix display.
module dooz_scan_timer #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYC    = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] row_idx,
    output logic       blank,
    output logic       frame_stb,
    output logic       blink
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    row_q, row_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;
    logic          row_tc_s;
    logic          frame_stb_s;

    assign row_tc_s    = (div_cnt_q == DW'(SCAN_DIV - 1));
    assign frame_stb_s = row_tc_s && (row_q == 2'd2);

    assign row_idx   = row_q;
    assign blank     = (div_cnt_q < DW'(BLANK_CYC));
    assign frame_stb = frame_stb_s;
    assign blink     = blink_q;

    // Next-state for the divider, row index, frame counter and blink phase.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (row_tc_s) begin
            div_cnt_d = {DW{1'b0}};
            if (row_q == 2'd2) begin
                row_d = 2'd0;
            end else begin
                row_d = row_q + 2'd1;
            end
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
        if (frame_stb_s) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = {FW{1'b0}};
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Timebase state registers; reset restarts at row 0 in the blink-off phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q   <= {DW{1'b0}};
            row_q       <= 2'd0;
            frame_cnt_q <= {FW{1'b0}};
            blink_q     <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

endmodule

// File: rtl/dooz_matrix_display.sv
// Dooz display stage: frame-synchronous input shadows, result FSM and the
// registered row/column drive for a row-scanned 3x3 bicolour LED matrix.
module dooz_matrix_display
    import dooz_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYC    = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CELLS-1:0] selectA,
    input  logic [CELLS-1:0] selectB,
    input  logic             turnA,
    input  logic             turnB,
    input  logic             winnerA,
    input  logic             winnerB,
    input  logic             equal,
    output logic [ROWS-1:0]  row_n,
    output logic [COLS-1:0]  col_red,
    output logic [COLS-1:0]  col_green,
    output logic             led_turnA,
    output logic             led_turnB,
    output logic             conflict
);

    logic [1:0] row_idx_s;
    logic       blank_s;
    logic       frame_stb_s;
    logic       blink_s;

    dooz_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .row_idx   (row_idx_s),
        .blank     (blank_s),
        .frame_stb (frame_stb_s),
        .blink     (blink_s)
    );

    logic [CELLS-1:0] sh_a_q, sh_b_q;
    logic             sh_turn_a_q, sh_turn_b_q;
    logic [1:0]       state_q, state_d;
    logic             conflict_q;
    logic [ROWS-1:0]  row_n_q, row_n_d;
    logic [COLS-1:0]  col_red_q, col_red_d;
    logic [COLS-1:0]  col_green_q, col_green_d;
    logic             led_turn_a_q, led_turn_a_d;
    logic             led_turn_b_q, led_turn_b_d;
    logic             any_result_s;
    logic             red_en_s, green_en_s;

    assign any_result_s = winnerA | winnerB | equal;

    // Result FSM next state, decided on the flags being latched into the
    // shadows at this boundary so state and board always describe one frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAY: begin
                if (winnerA) begin
                    state_d = WIN_A;
                end else if (winnerB) begin
                    state_d = WIN_B;
                end else if (equal) begin
                    state_d = DRAW;
                end else begin
                    state_d = PLAY;
                end
            end
            WIN_A: begin
                if (!any_result_s) begin
                    state_d = PLAY;
                end else begin
                    state_d = WIN_A;
                end
            end
            WIN_B: begin
                if (!any_result_s) begin
                    state_d = PLAY;
                end else if (winnerA) begin
                    state_d = WIN_A;
                end else begin
                    state_d = WIN_B;
                end
            end
            DRAW: begin
                if (!any_result_s) begin
                    state_d = PLAY;
                end else if (winnerA) begin
                    state_d = WIN_A;
                end else if (winnerB) begin
                    state_d = WIN_B;
                end else begin
                    state_d = DRAW;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // Frame-boundary capture of inputs, result state and conflict flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_a_q      <= {CELLS{1'b0}};
            sh_b_q      <= {CELLS{1'b0}};
            sh_turn_a_q <= 1'b0;
            sh_turn_b_q <= 1'b0;
            state_q     <= PLAY;
            conflict_q  <= 1'b0;
        end else if (frame_stb_s) begin
            sh_a_q      <= selectA;
            sh_b_q      <= selectB;
            sh_turn_a_q <= turnA;
            sh_turn_b_q <= turnB;
            state_q     <= state_d;
            conflict_q  <= |(selectA & selectB);
        end else begin
            sh_a_q      <= sh_a_q;
            sh_b_q      <= sh_b_q;
            sh_turn_a_q <= sh_turn_a_q;
            sh_turn_b_q <= sh_turn_b_q;
            state_q     <= state_q;
            conflict_q  <= conflict_q;
        end
    end

    // Column mux: blink gating per result state, blanking at row start.
    always_comb begin
        red_en_s     = 1'b1;
        green_en_s   = 1'b1;
        case (state_q)
            PLAY:    begin red_en_s = 1'b1;    green_en_s = 1'b1;    end
            WIN_A:   begin red_en_s = blink_s; green_en_s = 1'b1;    end
            WIN_B:   begin red_en_s = 1'b1;    green_en_s = blink_s; end
            DRAW:    begin red_en_s = blink_s; green_en_s = blink_s; end
            default: begin red_en_s = 1'b1;    green_en_s = 1'b1;    end
        endcase
        row_n_d = row_enable_n(row_idx_s);
        if (blank_s) begin
            col_red_d   = 3'b000;
            col_green_d = 3'b000;
        end else begin
            col_red_d   = row_cells(sh_a_q, row_idx_s) & {COLS{red_en_s}};
            col_green_d = row_cells(sh_b_q, row_idx_s) & {COLS{green_en_s}};
        end
        led_turn_a_d = sh_turn_a_q & (state_q == PLAY);
        led_turn_b_d = sh_turn_b_q & (state_q == PLAY);
    end

    // Output registers; reset blanks the matrix immediately, even mid-row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_n_q      <= 3'b111;
            col_red_q    <= 3'b000;
            col_green_q  <= 3'b000;
            led_turn_a_q <= 1'b0;
            led_turn_b_q <= 1'b0;
        end else begin
            row_n_q      <= row_n_d;
            col_red_q    <= col_red_d;
            col_green_q  <= col_green_d;
            led_turn_a_q <= led_turn_a_d;
            led_turn_b_q <= led_turn_b_d;
        end
    end

    assign row_n     = row_n_q;
    assign col_red   = col_red_q;
    assign col_green = col_green_q;
    assign led_turnA = led_turn_a_q;
    assign led_turnB = led_turn_b_q;
    assign conflict  = conflict_q;

endmodule
